sort_order_checker: RTL

SORT_ORDER_CHECKER -- requirements
Module: sort_order_checker

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_order_checker_if.sv | 15 +
 rtl/avst_skid_buf.sv | 68 ++++++
 rtl/sort_order_checker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the sort-order checker: FSM states,
// error-flag bit positions and the packet-length width helper.
package sort_pkg;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_IN_PKT = 1'b1
   } chk_state_e;

   localparam int ERR_W       = 3;
   localparam int ERR_ORDER   = 0;
   localparam int ERR_FRAMING = 1;
   localparam int ERR_OVERLEN = 2;

   // One extra bit so the saturated length MAX_PKT_LEN+1 always fits.
   function automatic int pkt_len_w(input int maxLen);
      return $clog2(maxLen) + 1;
   endfunction

endpackage

// File: rtl/sort_order_checker_if.sv
// Avalon-ST style streaming bus: data with start/end-of-packet framing and
// a valid/ready handshake.
interface sort_order_checker_if #(
   parameter int DWIDTH = 8
);
   logic [DWIDTH-1:0] data;
   logic              sop;
   logic              eop;
   logic              valid;
   logic              ready;

   modport master (output data, sop, eop, valid, input  ready);
   modport slave  (input  data, sop, eop, valid, output ready);

endinterface

// File: rtl/avst_skid_buf.sv
// Two-entry skid buffer: registered outputs, one cycle of latency and full
// throughput, with a registered ready that drops only when both entries hold data.
module avst_skid_buf #(
   parameter int DWIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   sort_order_checker_if.slave  snk,
   sort_order_checker_if.master src
);

   localparam int EW = DWIDTH + 2;

   logic [EW-1:0] ent0_q, ent0_d;
   logic [EW-1:0] ent1_q, ent1_d;
   logic          vld0_q, vld0_d;
   logic          vld1_q, vld1_d;
   logic          rdy_q,  rdy_d;
   logic          push;
   logic          pop;

   assign push = snk.valid & rdy_q;
   assign pop  = vld0_q & src.ready;

   // Entry 0 is always the head; a pop shifts entry 1 forward before any push lands.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      vld0_d = vld0_q;
      vld1_d = vld1_q;
      if (pop) begin
         ent0_d = ent1_q;
         vld0_d = vld1_q;
         vld1_d = 1'b0;
      end
      if (push) begin
         if (!vld0_d) begin
            ent0_d = {snk.data, snk.sop, snk.eop};
            vld0_d = 1'b1;
         end else begin
            ent1_d = {snk.data, snk.sop, snk.eop};
            vld1_d = 1'b1;
         end
      end
      rdy_d = !(vld0_d && vld1_d);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         ent0_q <= '0;
         ent1_q <= '0;
         vld0_q <= 1'b0;
         vld1_q <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         vld0_q <= vld0_d;
         vld1_q <= vld1_d;
         rdy_q  <= rdy_d;
      end
   end

   assign snk.ready                   = rdy_q;
   assign src.valid                   = vld0_q;
   assign {src.data, src.sop, src.eop} = ent0_q;

endmodule

// File: rtl/sort_order_checker.sv
// Pass-through stream monitor that checks each packet is sorted ascending and
// well framed, reporting per-packet status and running packet/error counts.
module sort_order_checker
   import sort_pkg::*;
#(
   parameter int DWIDTH      = 8,
   parameter int MAX_PKT_LEN = 256,
   parameter int CNT_W       = 16
) (
   input  logic                              clk_i,
   input  logic                              arst_n_i,
   input  logic [DWIDTH-1:0]                 snk_data_i,
   input  logic                              snk_startofpacket_i,
   input  logic                              snk_endofpacket_i,
   input  logic                              snk_valid_i,
   output logic                              snk_ready_o,
   output logic [DWIDTH-1:0]                 src_data_o,
   output logic                              src_startofpacket_o,
   output logic                              src_endofpacket_o,
   output logic                              src_valid_o,
   input  logic                              src_ready_i,
   output logic                              pkt_done_o,
   output logic [ERR_W-1:0]                  pkt_err_o,
   output logic [pkt_len_w(MAX_PKT_LEN)-1:0] pkt_len_o,
   output logic [CNT_W-1:0]                  pkt_cnt_o,
   output logic [CNT_W-1:0]                  err_cnt_o
);

   localparam int            LW      = pkt_len_w(MAX_PKT_LEN);
   localparam logic [LW-1:0] LEN_ONE = LW'(1);
   localparam logic [LW-1:0] LEN_LIM = LW'(MAX_PKT_LEN);
   localparam logic [LW-1:0] LEN_SAT = LW'(MAX_PKT_LEN + 1);

   sort_order_checker_if #(.DWIDTH(DWIDTH)) snk_if ();
   sort_order_checker_if #(.DWIDTH(DWIDTH)) src_if ();

   assign snk_if.data         = snk_data_i;
   assign snk_if.sop          = snk_startofpacket_i;
   assign snk_if.eop          = snk_endofpacket_i;
   assign snk_if.valid        = snk_valid_i;
   assign snk_ready_o         = snk_if.ready;
   assign src_data_o          = src_if.data;
   assign src_startofpacket_o = src_if.sop;
   assign src_endofpacket_o   = src_if.eop;
   assign src_valid_o         = src_if.valid;
   assign src_if.ready        = src_ready_i;

   avst_skid_buf #(.DWIDTH(DWIDTH)) u_skid (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .snk      (snk_if),
      .src      (src_if)
   );

   logic              accept;
   chk_state_e        state_q, state_d;
   logic [DWIDTH-1:0] prev_q, prev_d;
   logic [LW-1:0]     len_q, len_d, lenInc;
   logic              order_q, order_d, orderNew;
   logic              closeA, closeB;
   logic [ERR_W-1:0]  errA, errB;
   logic [LW-1:0]     lenA, lenB;
   logic              pend_q, pend_d;
   logic [ERR_W-1:0]  pendErr_q, pendErr_d;
   logic [LW-1:0]     pendLen_q, pendLen_d;
   logic              emitV;
   logic [ERR_W-1:0]  emitErr;
   logic [LW-1:0]     emitLen;
   logic              done_q;
   logic [ERR_W-1:0]  err_q;
   logic [LW-1:0]     lenOut_q;
   logic [CNT_W-1:0]  pktCnt_q, errCnt_q;

   assign accept = snk_valid_i & snk_ready_o;

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      len_d    = len_q;
      order_d  = order_q;
      closeA   = 1'b0;
      errA     = '0;
      lenA     = LEN_ONE;
      closeB   = 1'b0;
      errB     = '0;
      lenB     = LEN_ONE;
      lenInc   = (len_q == LEN_SAT) ? len_q : len_q + LEN_ONE;
      orderNew = order_q | (snk_data_i < prev_q);
      if (accept) begin
         if (state_q == S_IN_PKT && !snk_startofpacket_i) begin
            prev_d  = snk_data_i;
            len_d   = lenInc;
            order_d = orderNew;
            if (snk_endofpacket_i) begin
               closeA            = 1'b1;
               errA[ERR_ORDER]   = orderNew;
               errA[ERR_OVERLEN] = (lenInc > LEN_LIM);
               lenA              = lenInc;
               state_d           = S_IDLE;
            end
         end else begin
            // A sop inside a packet closes the old one, so sop+eop here yields two closes.
            if (state_q == S_IN_PKT) begin
               closeA            = 1'b1;
               errA[ERR_ORDER]   = order_q;
               errA[ERR_FRAMING] = 1'b1;
               errA[ERR_OVERLEN] = (len_q > LEN_LIM);
               lenA              = len_q;
            end
            if (snk_startofpacket_i && !snk_endofpacket_i) begin
               prev_d  = snk_data_i;
               len_d   = LEN_ONE;
               order_d = 1'b0;
               state_d = S_IN_PKT;
            end else begin
               state_d = S_IDLE;
               if (closeA) begin
                  closeB            = 1'b1;
                  errB[ERR_FRAMING] = !snk_startofpacket_i;
               end else begin
                  closeA            = 1'b1;
                  errA[ERR_FRAMING] = !snk_startofpacket_i;
               end
            end
         end
      end
   end

   // A deferred second close always drains before the next double close can occur.
   always_comb begin
      pend_d    = 1'b0;
      pendErr_d = pendErr_q;
      pendLen_d = pendLen_q;
      emitV     = 1'b0;
      emitErr   = errA;
      emitLen   = lenA;
      if (pend_q) begin
         emitV     = 1'b1;
         emitErr   = pendErr_q;
         emitLen   = pendLen_q;
         pend_d    = closeA;
         pendErr_d = errA;
         pendLen_d = lenA;
      end else if (closeA) begin
         emitV     = 1'b1;
         pend_d    = closeB;
         pendErr_d = errB;
         pendLen_d = lenB;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q   <= S_IDLE;
         prev_q    <= '0;
         len_q     <= '0;
         order_q   <= 1'b0;
         pend_q    <= 1'b0;
         pendErr_q <= '0;
         pendLen_q <= '0;
         done_q    <= 1'b0;
         err_q     <= '0;
         lenOut_q  <= '0;
         pktCnt_q  <= '0;
         errCnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         len_q     <= len_d;
         order_q   <= order_d;
         pend_q    <= pend_d;
         pendErr_q <= pendErr_d;
         pendLen_q <= pendLen_d;
         done_q    <= emitV;
         if (emitV) begin
            err_q    <= emitErr;
            lenOut_q <= emitLen;
            if (pktCnt_q != '1) pktCnt_q <= pktCnt_q + 1'b1;
            if (emitErr != '0 && errCnt_q != '1) errCnt_q <= errCnt_q + 1'b1;
         end
      end
   end

   assign pkt_done_o = done_q;
   assign pkt_err_o  = err_q;
   assign pkt_len_o  = lenOut_q;
   assign pkt_cnt_o  = pktCnt_q;
   assign err_cnt_o  = errCnt_q;

endmodule
